// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path.
//   state_t  : controller state encoding for the sequential BCD converter
//   DIV_*    : divisors applied in successive division steps
//   BCD4_MAX : largest value representable in four BCD digits
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_D1000 = 3'd1,
    ST_D100  = 3'd2,
    ST_D10   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DIV_1000 = 1000;
  localparam int DIV_100  = 100;
  localparam int DIV_10   = 10;
  localparam int BCD4_MAX = 9999;

endpackage

// File: rtl/div_N.sv
// Restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle pulse; samples dividend/divisor
//   dividend, divisor   : operands (bits wide)
//   quotient, remainder : results, valid while rdy is high
//   rdy                 : one-cycle pulse, bits+1 cycles after start
// A start while a division is running restarts it with the new operands.
module div_N #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [bits-1:0] dividend,
  input  logic [bits-1:0] divisor,
  output logic [bits-1:0] quotient,
  output logic [bits-1:0] remainder,
  output logic            rdy
);

  localparam int CW = $clog2(bits + 1);

  logic [bits-1:0] dvsr;
  logic [bits-1:0] rem;
  logic [bits-1:0] quo;
  logic [CW-1:0]   cnt;
  logic            running;
  logic [bits:0]   shifted;
  logic [bits:0]   trial;

  // Partial remainder stays below the divisor, so shifted < 2*divisor and
  // the top bit of trial is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[bits-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr    <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (start) begin
        dvsr    <= divisor;
        rem     <= '0;
        quo     <= dividend;
        cnt     <= CW'(bits);
        running <= 1'b1;
      end else if (running) begin
        if (!trial[bits]) begin
          rem <= trial[bits-1:0];
          quo <= {quo[bits-2:0], 1'b1};
        end else begin
          rem <= shifted[bits-1:0];
          quo <= {quo[bits-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          rdy     <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/bcd_div_seq.sv
// Sequential binary-to-BCD converter sharing one divider across the
// thousands, hundreds and tens steps.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : conversion request, honoured in IDLE or DONE only
//   bin             : binary operand, captured when start is accepted
//   busy            : conversion in progress (D1000/D100/D10)
//   done            : one-cycle pulse, outputs valid in this cycle
//   ovf             : last accepted operand exceeded 9999
//   dig1000..dig1   : registered BCD digits, held until the next DONE
//   dbg_state       : current controller state (calc_pkg::state_t encoding)
// Handshake: start is a request sampled on the rising edge whenever busy
// is low; a conversion, once accepted, always ends with exactly one done
// pulse and cannot be cancelled except by rst. Requests while busy are
// dropped, not queued.
module bcd_div_seq
  import calc_pkg::*;
#(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [bits-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [3:0]      dig1000,
  output logic [3:0]      dig100,
  output logic [3:0]      dig10,
  output logic [3:0]      dig1,
  output logic [2:0]      dbg_state
);

  localparam logic [bits-1:0] MAX_B  = bits'(BCD4_MAX);
  localparam logic [bits-1:0] D1000B = bits'(DIV_1000);
  localparam logic [bits-1:0] D100B  = bits'(DIV_100);
  localparam logic [bits-1:0] D10B   = bits'(DIV_10);

  state_t          state;
  state_t          state_nxt;
  logic [bits-1:0] opnd;
  logic [bits-1:0] rem_q;
  logic [3:0]      stg1000;
  logic [3:0]      stg100;
  logic            div_start;
  logic [bits-1:0] div_dividend;
  logic [bits-1:0] div_divisor;
  logic [bits-1:0] div_q;
  logic [bits-1:0] div_r;
  logic            div_rdy;
  logic            accept;
  logic            in_range;
  logic            unused_q_hi;

  // In-range inputs give quotients of at most 9 at every step.
  assign unused_q_hi = |div_q[bits-1:4];

  div_N #(.bits(bits)) u_div (
    .clk       (clk),
    .reset     (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_q),
    .remainder (div_r),
    .rdy       (div_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    in_range     = (bin <= MAX_B);
    busy         = 1'b0;
    done         = 1'b0;
    div_divisor  = D10B;
    div_dividend = rem_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        done   = (state == ST_DONE);
        accept = start;
        if (start) state_nxt = in_range ? ST_D1000 : ST_DONE;
        else       state_nxt = ST_IDLE;
      end
      ST_D1000: begin
        busy         = 1'b1;
        div_divisor  = D1000B;
        div_dividend = opnd;
        if (div_rdy) state_nxt = ST_D100;
      end
      ST_D100: begin
        busy        = 1'b1;
        div_divisor = D100B;
        if (div_rdy) state_nxt = ST_D10;
      end
      ST_D10: begin
        busy        = 1'b1;
        div_divisor = D10B;
        if (div_rdy) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output registers load on the edge that enters DONE so that they are
  // already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd      <= '0;
      rem_q     <= '0;
      stg1000   <= '0;
      stg100    <= '0;
      div_start <= 1'b0;
      ovf       <= 1'b0;
      dig1000   <= '0;
      dig100    <= '0;
      dig10     <= '0;
      dig1      <= '0;
    end else begin
      div_start <= 1'b0;
      if (accept) begin
        opnd <= bin;
        if (in_range) begin
          div_start <= 1'b1;
        end else begin
          ovf     <= 1'b1;
          dig1000 <= '0;
          dig100  <= '0;
          dig10   <= '0;
          dig1    <= '0;
        end
      end
      if (div_rdy) begin
        case (state)
          ST_D1000: begin
            stg1000   <= div_q[3:0];
            rem_q     <= div_r;
            div_start <= 1'b1;
          end
          ST_D100: begin
            stg100    <= div_q[3:0];
            rem_q     <= div_r;
            div_start <= 1'b1;
          end
          ST_D10: begin
            rem_q   <= div_r;
            ovf     <= 1'b0;
            dig1000 <= stg1000;
            dig100  <= stg100;
            dig10   <= div_q[3:0];
            dig1    <= div_r[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bcd_div_seq.sv
// Bench for bcd_div_seq: directed conversions checked against a
// cycle-level model derived from the latency rule, plus literal results.
module tb_bcd_div_seq;

  localparam int BITS     = 16;
  localparam int DIV_LAT  = BITS + 1;          // div_N: start to rdy
  localparam int CONV_LAT = 4 + 3 * DIV_LAT;   // start to done (55)

  // clock / reset
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] bin = '0;
  logic            busy, done, ovf;
  logic [3:0]      dig1000, dig100, dig10, dig1;
  logic [2:0]      dbg_state;

  always #5 clk = ~clk;

  bcd_div_seq #(.bits(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dig1000   (dig1000),
    .dig100    (dig100),
    .dig10     (dig10),
    .dig1      (dig1),
    .dbg_state (dbg_state)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int ds_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // behavioural model: expected outputs for the cycle that follows each edge
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  logic            m_ovf  = 1'b0;
  logic [15:0]     m_dig  = '0;
  int              m_done_cyc = 0;
  logic [BITS-1:0] exp_q[$];

  always @(posedge clk) begin
    logic [BITS-1:0] v;
    cyc = cyc + 1;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_dig  = '0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy && start) begin
        if (int'(bin) > 9999) begin
          m_done = 1'b1;
          m_ovf  = 1'b1;
          m_dig  = '0;
        end else begin
          exp_q.push_back(bin);
          m_done_cyc = cyc - 1 + CONV_LAT;
        end
      end
      if (exp_q.size() > 0 && cyc == m_done_cyc) begin
        v      = exp_q.pop_front();
        m_dig  = to_bcd(int'(v));
        m_ovf  = 1'b0;
        m_done = 1'b1;
      end
      m_busy = (exp_q.size() > 0);
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    logic [18:0] act, exp;
    act = {busy, done, ovf, dig1000, dig100, dig10, dig1};
    exp = rst ? 19'd0 : {m_busy, m_done, m_ovf, m_dig};
    chk("cycle_outputs", 32'(act), 32'(exp));
    if (done) done_cnt++;
    if (dut.div_start) ds_cnt++;
  end

  // driver tasks
  task automatic pulse_start(input int v, output int s);
    @(posedge clk); #1;
    start = 1'b1;
    bin   = BITS'(v);
    s     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total_cnt++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  function automatic logic [15:0] digs();
    digs = {dig1000, dig100, dig10, dig1};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, at, at1, at2, at3, ds0, dn0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'({busy, done, ovf, digs()}), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);

    // 1234: single conversion
    ds0 = ds_cnt; dn0 = done_cnt;
    pulse_start(1234, s);
    wait_done(CONV_LAT + 20, at);
    chk("lat_1234", 32'(at - s), 32'd55);
    repeat (3) @(negedge clk);
    chk("dig_1234", 32'(digs()), 32'h1234);
    chk("ovf_1234", 32'(ovf), 32'd0);
    chk("done_cnt_1234", 32'(done_cnt - dn0), 32'd1);
    chk("div_starts_1234", 32'(ds_cnt - ds0), 32'd3);

    // 9999 then 0, outputs hold across the second conversion
    pulse_start(9999, s);
    wait_done(CONV_LAT + 20, at);
    chk("dig_9999", 32'(digs()), 32'h9999);
    pulse_start(0, s);
    repeat (20) @(negedge clk);
    chk("hold_9999", 32'(digs()), 32'h9999);
    wait_done(CONV_LAT + 20, at);
    chk("dig_0", 32'(digs()), 32'h0000);

    // overflow path
    repeat (2) @(negedge clk);
    ds0 = ds_cnt;
    pulse_start(10000, s);
    wait_done(5, at);
    chk("lat_ovf", 32'(at - s), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("dig_ovf", 32'(digs()), 32'h0000);
    repeat (2) @(negedge clk);
    chk("div_starts_ovf", 32'(ds_cnt - ds0), 32'd0);

    // start mid-conversion ignored
    dn0 = done_cnt;
    pulse_start(5678, s);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; bin = BITS'(4321);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(CONV_LAT + 20, at);
    chk("dig_5678", 32'(digs()), 32'h5678);
    repeat (70) @(negedge clk);
    chk("done_cnt_5678", 32'(done_cnt - dn0), 32'd1);

    // reset during D100
    pulse_start(2468, s);
    repeat (23) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({busy, done, ovf, digs()}), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulse_start(42, s);
    wait_done(CONV_LAT + 20, at);
    chk("dig_0042", 32'(digs()), 32'h0042);

    // start held high: back-to-back conversions
    repeat (2) @(posedge clk);
    #1 start = 1'b1; bin = BITS'(808);
    s = cyc;
    wait_done(CONV_LAT + 20, at1);
    wait_done(CONV_LAT + 20, at2);
    wait_done(CONV_LAT + 20, at3);
    start = 1'b0;
    chk("b2b_first", 32'(at1 - s), 32'd55);
    chk("b2b_period1", 32'(at2 - at1), 32'd55);
    chk("b2b_period2", 32'(at3 - at2), 32'd55);
    chk("dig_0808", 32'(digs()), 32'h0808);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
